// File: rtl/dmem_access_ctrl.sv
// Requester-side controller for the dual-port Data_Mem BRAM: single-word writes on port A,
// flow-controlled burst reads on port B returned through a small response FIFO.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_doutb
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LAT + 2);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBurst = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]     PTR_MAX  = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;

    logic [RD_LAT:0]   vld_q, vld_d;
    logic [RD_LAT:0]   last_q, last_d;
    logic              issue, issue_last;

    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         in_flight;

    logic push, pop, room, drain_done, accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= int'(RD_LAT); i++) begin
            in_flight = in_flight + CW'(vld_q[i]);
        end
    end

    assign push   = vld_q[RD_LAT];
    assign pop    = resp_valid && resp_ready;
    assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
    // Every issued read already owns a FIFO slot, so the buffer can never overflow.
    assign room   = (cnt_q + in_flight - CW'(pop)) < DEPTH_C;
    assign drain_done = (in_flight == CW'(push)) && (cnt_d == '0);
    assign accept = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        addra_d     = addra_q;
        dina_d      = dina_q;
        wea_d       = 1'b0;
        addrb_d     = addrb_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_we) begin
                        wea_d   = 1'b1;
                        addra_d = req_addr;
                        dina_d  = req_wdata;
                    end else begin
                        issue       = 1'b1;
                        issue_last  = (req_len == '0);
                        addrb_d     = req_addr;
                        len_d       = req_len;
                        issue_cnt_d = CNT_ONE;
                        state_d     = issue_last ? StDrain : StBurst;
                    end
                end
            end
            StBurst: begin
                if (room) begin
                    issue       = 1'b1;
                    addrb_d     = addrb_q + ADDR_ONE;
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    if (issue_cnt_q == {1'b0, len_q}) begin
                        issue_last = 1'b1;
                        state_d    = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Valid/last bits follow each issued read until its word appears on mem_doutb.
    always_comb begin
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = issue;
        last_d[0] = issue_last;
        for (int i = 1; i <= int'(RD_LAT); i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issue_cnt_q <= '0;
            addra_q     <= '0;
            dina_q      <= '0;
            wea_q       <= 1'b0;
            addrb_q     <= '0;
            vld_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            wea_q       <= wea_d;
            addrb_q     <= addrb_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wptr_q] <= mem_doutb;
                fifo_last_q[wptr_q] <= last_q[RD_LAT];
                wptr_q              <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q <= cnt_d;
        end
    end

    assign resp_valid = (cnt_q != '0);
    assign resp_data  = resp_valid ? fifo_data_q[rptr_q] : '0;
    assign resp_last  = resp_valid && fifo_last_q[rptr_q];
    assign req_ready  = rst_n && (state_q == StIdle);

    assign mem_addra = addra_q;
    assign mem_dina  = dina_q;
    assign mem_wea   = wea_q;
    assign mem_addrb = addrb_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural Data_Mem (read latency 1) and a response scoreboard.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [ADDR_W-1:0] req_len = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;
    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addrb;
    logic [DATA_W-1:0] mem_doutb;

    int checks = 0;
    int failures = 0;
    int pops = 0;

    logic [DATA_W-1:0] exp_mem [256];
    logic [DATA_W-1:0] exp_d [$];
    logic              exp_l [$];
    logic [DATA_W-1:0] ram [256];

    dmem_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last),
        .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_wea(mem_wea),
        .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wea) ram[mem_addra] <= mem_dina;
        mem_doutb <= ram[mem_addrb];
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] ed;
        logic              el;
        if (rst_n && resp_valid && resp_ready) begin
            pops++;
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp: got data=%h last=%b, required no response",
                         resp_data, resp_last);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                if (resp_data !== ed || resp_last !== el) begin
                    failures++;
                    $display("FAIL resp_word: got data=%h last=%b, required data=%h last=%b",
                             resp_data, resp_last, ed, el);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        exp_mem[a] = d;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] ad;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_len   = len;
        for (int i = 0; i <= int'(len); i++) begin
            ad = a + ADDR_W'(i);
            exp_d.push_back(exp_mem[ad]);
            exp_l.push_back(i == int'(len));
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (exp_d.size() == 0 && req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #20;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: got ready=%b valid=%b last=%b, required 0 0 0",
                     req_ready, resp_valid, resp_last);
        end
        checks++;
        if (resp_data !== '0 || mem_wea !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got data=%h wea=%b, required 0 0", resp_data, mem_wea);
        end
        checks++;
        if (mem_addra !== '0 || mem_dina !== '0 || mem_addrb !== '0) begin
            failures++;
            $display("FAIL reset_mem: got addra=%h dina=%h addrb=%h, required 0 0 0",
                     mem_addra, mem_dina, mem_addrb);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        do_write(8'd3, 64'hA5A5_0000_0000_0001);
        checks++;
        if (mem_wea !== 1'b1 || mem_addra !== 8'd3 || mem_dina !== 64'hA5A5_0000_0000_0001) begin
            failures++;
            $display("FAIL write_port: got wea=%b addra=%h dina=%h, required 1 03 a5a5000000000001",
                     mem_wea, mem_addra, mem_dina);
        end
        do_read(8'd3, 8'd0);
        checks++;
        if (mem_wea !== 1'b0) begin
            failures++;
            $display("FAIL wea_one_cycle: got %b, required 0", mem_wea);
        end
        checks++;
        if (mem_addrb !== 8'd3 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_issue: got addrb=%h valid=%b, required 03 0", mem_addrb, resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL resp_early: got valid=%b one edge after accept, required 0", resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'hA5A5_0000_0000_0001 || resp_last !== 1'b1) begin
            failures++;
            $display("FAIL resp_latency: got valid=%b data=%h last=%b, required 1 a5a5000000000001 1",
                     resp_valid, resp_data, resp_last);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_pop: got %b, required 0", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_pop: got ready=%b valid=%b, required 1 0",
                     req_ready, resp_valid);
        end
        wait_idle(5, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_read_idle: got pending=%0d, required 0", exp_d.size());
        end
    endtask

    task automatic test_burst();
        bit ok;
        int n;
        for (int i = 0; i < 4; i++) begin
            do_write(ADDR_W'(i), DATA_W'(16 + i));
            checks++;
            if (mem_wea !== 1'b1 || mem_addra !== ADDR_W'(i)) begin
                failures++;
                $display("FAIL b2b_write: got wea=%b addra=%h, required 1 %h",
                         mem_wea, mem_addra, ADDR_W'(i));
            end
        end
        do_read(8'd0, 8'd3);
        n = 0;
        while (resp_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (resp_valid !== 1'b1) begin
                failures++;
                $display("FAIL burst_stream: got valid=%b at word %0d, required 1", resp_valid, k);
            end
            tick();
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL burst_end: got valid=%b, required 0", resp_valid);
        end
        wait_idle(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL burst_idle: got pending=%0d, required 0", exp_d.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [ADDR_W-1:0] ea;
        do_write(8'd254, 64'hFE);
        do_write(8'd255, 64'hFF);
        do_write(8'd0, 64'h00);
        do_write(8'd1, 64'h01);
        do_read(8'd254, 8'd3);
        for (int k = 0; k < 4; k++) begin
            ea = ADDR_W'(254 + k);
            checks++;
            if (mem_addrb !== ea) begin
                failures++;
                $display("FAIL wrap_addrb: got %h at issue %0d, required %h", mem_addrb, k, ea);
            end
            tick();
        end
        wait_idle(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wrap_idle: got pending=%0d, required 0", exp_d.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit prev_stall;
        logic [DATA_W-1:0] prev_data;
        int base;
        int issued;
        for (int i = 0; i < 8; i++) begin
            do_write(ADDR_W'(16 + i), 64'hB000_0000_0000_0000 | DATA_W'(i));
        end
        base = pops;
        do_read(8'd16, 8'd7);
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 80 && exp_d.size() != 0; c++) begin
            if (prev_stall) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b data=%h, required 1 %h",
                             resp_valid, resp_data, prev_data);
                end
            end
            issued = int'(mem_addrb) - 16 + 1;
            checks++;
            if (issued - (pops - base) > int'(FIFO_DEPTH)) begin
                failures++;
                $display("FAIL outstanding: got %0d, required <= %0d",
                         issued - (pops - base), FIFO_DEPTH);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_burst: got %b, required 0", req_ready);
            end
            resp_ready = (c % 4 == 0) || (c % 4 == 3);
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_data;
            tick();
        end
        resp_ready = 1'b1;
        checks++;
        if (pops - base != 8) begin
            failures++;
            $display("FAIL backpressure_count: got %0d words, required 8", pops - base);
        end
        wait_idle(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL backpressure_idle: got pending=%0d, required 0", exp_d.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int base;
        int seen;
        for (int i = 0; i < 8; i++) begin
            do_write(ADDR_W'(32 + i), 64'hC000_0000_0000_0000 | DATA_W'(i));
        end
        base = pops;
        do_read(8'd32, 8'd7);
        for (int c = 0; c < 20 && (pops - base) < 2; c++) begin
            tick();
        end
        checks++;
        if (pops - base < 2) begin
            failures++;
            $display("FAIL midburst_timeout: got %0d words, required 2", pops - base);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_last !== 1'b0 || resp_data !== '0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL midburst_reset_resp: got valid=%b last=%b data=%h ready=%b, required 0",
                     resp_valid, resp_last, resp_data, req_ready);
        end
        checks++;
        if (mem_addrb !== '0 || mem_wea !== 1'b0) begin
            failures++;
            $display("FAIL midburst_reset_mem: got addrb=%h wea=%b, required 0 0",
                     mem_addrb, mem_wea);
        end
        exp_d.delete();
        exp_l.delete();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midburst_release_ready: got %b, required 1", req_ready);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midburst_stale: got %0d valid cycles, required 0", seen);
        end
        do_read(8'd0, 8'd0);
        wait_idle(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL post_reset_read: got pending=%0d, required 0", exp_d.size());
        end
    endtask

    task automatic test_write_in_burst();
        bit ok;
        do_read(8'd16, 8'd7);
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 8'd16;
            req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
            checks++;
            if (mem_wea !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL write_ignored: got wea=%b ready=%b, required 0 0",
                         mem_wea, req_ready);
            end
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        wait_idle(30, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_in_burst_idle: got pending=%0d, required 0", exp_d.size());
        end
        do_read(8'd16, 8'd0);
        wait_idle(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reread_idle: got pending=%0d, required 0", exp_d.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        test_write_in_burst();
        checks++;
        if (exp_d.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_d.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Requester-side controller for the dual-port Data_Mem BRAM (8-bit address, 64-bit words, port A write-only, port B read-only).
- Accepts single-word write requests and burst read requests over a valid/ready interface.
- Drives both memory ports from one clock and returns read data through a backpressure-capable response stream.
- Sits between the datapath or host register logic and Data_Mem; clka and clkb are both tied to clk.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 64, memory word width.
- RD_LAT, 1, cycles from the clk edge that samples mem_addrb until mem_doutb is valid for capture.
- FIFO_DEPTH, 4, response buffer entries; must be >= RD_LAT+2.

Ports:
- clk  in  1  single clock for controller and both memory ports.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on clk edge when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = burst read.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  write data (ignored for reads).
- req_len  in  ADDR_W  read burst length minus 1 (0 = 1 word, 255 = 256 words); ignored for writes.
- resp_valid  out  1  resp_data valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_W  read word.
- resp_last  out  1  final word of the burst.
- mem_addra  out  ADDR_W  to Data_Mem addra.
- mem_dina  out  DATA_W  to Data_Mem dina.
- mem_wea  out  1  to Data_Mem wea.
- mem_addrb  out  ADDR_W  to Data_Mem addrb.
- mem_doutb  in  DATA_W  from Data_Mem doutb.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 while asserted, then 1 in IDLE; resp_valid=0; resp_last=0; resp_data=0; mem_wea=0; mem_addra=0; mem_dina=0; mem_addrb=0; counters and FIFO cleared; in-flight reads discarded.
- All mem_* outputs are registered.
- FSM states: IDLE, BURST, DRAIN. req_ready=1 only in IDLE.
- IDLE, write accepted:
  - Next edge: mem_addra<=req_addr, mem_dina<=req_wdata, mem_wea<=1 for exactly one cycle.
  - State stays IDLE.
  - A back-to-back write the following cycle is allowed; mem_wea then stays high.
- IDLE, read accepted:
  - Latch base address and req_len; issue count=0; go to BURST.
  - The first issue happens in the same edge: mem_addrb<=req_addr.
- BURST: each cycle, issue the next read (mem_addrb<=previous+1) iff occupancy + in_flight - pop < FIFO_DEPTH.
  - pop = resp_valid && resp_ready.
  - Address increments modulo 2^ADDR_W (255 wraps to 0).
  - After req_len+1 issues, go to DRAIN.
- In-flight tracking: a shift register of RD_LAT+1 valid bits with a last-flag pipeline. A word is captured from mem_doutb into the FIFO RD_LAT+1 edges after its issue edge.
  - With RD_LAT=1, resp_valid rises 2 edges after read acceptance.
- DRAIN: wait until in_flight=0 and FIFO empty (the last word popped), then return to IDLE. req_ready=1 on the cycle after the last pop.
- Response stream:
  - resp_data and resp_last reflect the FIFO head and are held stable while resp_valid && !resp_ready.
  - No words are lost or duplicated.
  - resp_last=1 only on word req_len+1.
- Throughput: with resp_ready held high, one word per cycle after the initial latency.
- A write followed immediately by a read of the same address returns the new data. The registered write lands one edge before the read address is sampled.
- req_valid outside IDLE is ignored; no latching occurs.
- Reset mid-burst or mid-drain: immediate return to the reset state. Any partially returned burst is abandoned; the consumer receives no resp_last.

Test Plan:
- Bench: Data_Mem instance with clka=clkb=clk; clock period 100 ns.
- Write 0xA5A5_0000_0000_0001 to addr 3, then read addr 3 with len 0 -> mem_wea high for one cycle with addra=3. resp_valid rises 2 edges after read acceptance with data 0xA5A5_0000_0000_0001 and resp_last=1. req_ready returns to 1 the cycle after the pop.
- Write words 0x10..0x13 to addrs 0..3, then burst read addr 0, len 3, resp_ready=1 -> 4 consecutive resp_valid cycles with data 0x10, 0x11, 0x12, 0x13; resp_last only on 0x13.
- Write 0xFE, 0xFF, 0x00, 0x01 to addrs 254, 255, 0, 1, then burst read addr 254, len 3 -> mem_addrb sequence 254, 255, 0, 1; data in that order.
- Burst read of 8 words with resp_ready toggling 1-0-0-1 -> at most FIFO_DEPTH outstanding; data held stable while stalled; all 8 words delivered in order; req_ready=0 throughout.
- Assert rst_n=0 for one cycle after the 2nd word of a len-7 burst -> all outputs return to reset values immediately. No further resp_valid; req_ready=1 after reset release; a new read of addr 0 succeeds.
- Assert req_valid with a write during BURST -> ignored: mem_wea stays 0 and memory is unchanged.
